// File: rtl/bridge_spi_arbiter.sv
// Two-port transaction arbiter for the bridge's shared SPI-master byte engine: round-robin grant,
// CS held per transaction, RX routing. Define ARB_TIMEOUT_EN to add the hung-grant watchdog.
`timescale 1ns/1ps
module bridge_spi_arbiter #(
  parameter int TIMEOUT_W = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       rel0,
  input  logic       rel1,
  input  logic       tx0_valid,
  input  logic       tx1_valid,
  input  logic [7:0] tx0_data,
  input  logic [7:0] tx1_data,
  output logic       tx0_ready,
  output logic       tx1_ready,
  output logic       gnt0,
  output logic       gnt1,
  output logic       m_valid,
  output logic [7:0] m_data,
  input  logic       m_ready,
  output logic       m_cs_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx0_valid,
  output logic       rx1_valid,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [2:0] {S_IDLE, S_GRANT0, S_GRANT1, S_DRAIN, S_GAP} state_t;

  state_t     state_reg, state_next;
  logic [1:0] gnt_reg, gnt_next;
  logic       cs_n_reg, cs_n_next;
  logic       inflight_reg, inflight_next;
  logic       owner_reg, owner_next;
  logic       last_winner_reg, last_winner_next;
  logic       winner;

  logic [1:0] req_v, rel_v, tx_valid_v, tx_ready_v, rx_valid_v;
  logic [7:0] tx_data_v [2];
  logic       granted, active, cur, hs, rx_done, release_req, wdog_expired;
  logic       timeout_next;

  assign req_v        = {req1, req0};
  assign rel_v        = {rel1, rel0};
  assign tx_valid_v   = {tx1_valid, tx0_valid};
  assign tx_data_v[0] = tx0_data;
  assign tx_data_v[1] = tx1_data;

  assign granted     = (state_reg == S_GRANT0) || (state_reg == S_GRANT1);
  assign active      = granted || (state_reg == S_DRAIN);
  assign cur         = (state_reg == S_GRANT1);
  assign m_valid     = granted & tx_valid_v[cur] & ~inflight_reg;
  assign m_data      = tx_data_v[cur];
  assign hs          = m_valid & m_ready;
  assign rx_done     = rx_valid & inflight_reg;
  assign release_req = granted & (rel_v[cur] | ~req_v[cur]);

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign tx_ready_v[gi] = granted & (cur == (gi == 1)) & m_ready & ~inflight_reg;
    assign rx_valid_v[gi] = rx_done & active & (owner_reg == (gi == 1));
  end

  assign tx0_ready = tx_ready_v[0];
  assign tx1_ready = tx_ready_v[1];
  assign rx0_valid = rx_valid_v[0];
  assign rx1_valid = rx_valid_v[1];
  assign gnt0      = gnt_reg[0];
  assign gnt1      = gnt_reg[1];
  assign m_cs_n    = cs_n_reg;
  assign busy      = (state_reg != S_IDLE);

  // Received byte itself is routed outside the arbiter; only rx_valid is qualified here.
  logic rx_data_unused;
  assign rx_data_unused = ^rx_data;

`ifdef ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wdog_reg, wdog_next;
  logic                 timeout_reg;

  always_comb begin
    wdog_next    = '0;
    wdog_expired = 1'b0;
    if (active && !(hs || rx_valid)) begin
      if (&wdog_reg) wdog_expired = 1'b1;
      else           wdog_next    = wdog_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      wdog_reg    <= wdog_next;
      timeout_reg <= timeout_next;
    end
  end

  assign timeout = timeout_reg;
`else
  localparam int TIMEOUT_W_UNUSED = TIMEOUT_W;
  assign wdog_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_comb begin
    state_next       = state_reg;
    gnt_next         = gnt_reg;
    cs_n_next        = cs_n_reg;
    owner_next       = owner_reg;
    last_winner_next = last_winner_reg;
    timeout_next     = 1'b0;
    winner           = 1'b0;
    inflight_next    = inflight_reg;
    if (hs) begin
      inflight_next = 1'b1;
      owner_next    = cur;
    end else if (rx_done) begin
      inflight_next = 1'b0;
    end

    case (state_reg)
      S_IDLE: begin
        if (|req_v) begin
          winner           = (req_v == 2'b11) ? ~last_winner_reg : req_v[1];
          state_next       = winner ? S_GRANT1 : S_GRANT0;
          gnt_next         = winner ? 2'b10 : 2'b01;
          cs_n_next        = 1'b0;
          last_winner_next = winner;
          owner_next       = winner;
        end
      end
      S_GRANT0, S_GRANT1, S_DRAIN: begin
        if (wdog_expired) begin
          state_next    = S_GAP;
          gnt_next      = 2'b00;
          cs_n_next     = 1'b1;
          inflight_next = 1'b0;
          timeout_next  = 1'b1;
        end else if ((release_req && !inflight_next) || (state_reg == S_DRAIN && rx_done)) begin
          state_next = S_GAP;
          gnt_next   = 2'b00;
          cs_n_next  = 1'b1;
        end else if (release_req) begin
          // A byte is still on the wire: keep CS low until its RX completes.
          state_next = S_DRAIN;
        end
      end
      S_GAP: state_next = S_IDLE;
      default: begin
        state_next = S_IDLE;
        gnt_next   = 2'b00;
        cs_n_next  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      gnt_reg         <= 2'b00;
      cs_n_reg        <= 1'b1;
      inflight_reg    <= 1'b0;
      owner_reg       <= 1'b0;
      last_winner_reg <= 1'b1;
    end else begin
      state_reg       <= state_next;
      gnt_reg         <= gnt_next;
      cs_n_reg        <= cs_n_next;
      inflight_reg    <= inflight_next;
      owner_reg       <= owner_next;
      last_winner_reg <= last_winner_next;
    end
  end

endmodule

// File: tb/tb_bridge_spi_arbiter.sv
// Directed/randomized bench for bridge_spi_arbiter with a transaction-level round-robin model.
// Builds with or without ARB_TIMEOUT_EN; the DUT watchdog is sized to 4 bits.
`timescale 1ns/1ps
module tb_bridge_spi_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req, rel, tx_valid, tx_ready, gnt, rxv;
  logic [7:0] tx_data [2];
  logic       m_valid, m_ready, m_cs_n, rx_valid, busy, timeout;
  logic [7:0] m_data, rx_data;

  int   n_total = 0;
  int   n_pass  = 0;
  logic exp_last;   // model: port that won the most recent grant

  always #5 clk = ~clk;

  bridge_spi_arbiter #(.TIMEOUT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req[0]), .req1(req[1]), .rel0(rel[0]), .rel1(rel[1]),
    .tx0_valid(tx_valid[0]), .tx1_valid(tx_valid[1]),
    .tx0_data(tx_data[0]), .tx1_data(tx_data[1]),
    .tx0_ready(tx_ready[0]), .tx1_ready(tx_ready[1]),
    .gnt0(gnt[0]), .gnt1(gnt[1]),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .m_cs_n(m_cs_n),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .rx0_valid(rxv[0]), .rx1_valid(rxv[1]),
    .busy(busy), .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic rr_pick(input logic [1:0] r, input logic last);
    if (r == 2'b11) return ~last;
    return r[1];
  endfunction

  task automatic clear_inputs();
    req = '0; rel = '0; tx_valid = '0; tx_data[0] = '0; tx_data[1] = '0;
    m_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    rx_valid = 1'b1;
    tick();
    tick();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_cs_n", m_cs_n, 1'b1);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_rxv", rxv, 2'b00);
    rx_valid = 1'b0;
    rst_n = 1'b1;
    exp_last = 1'b1;
  endtask

  task automatic wait_grant(output int who);
    who = -1;
    for (int i = 0; i < 8 && who < 0; i++) begin
      if (gnt == 2'b01) who = 0;
      else if (gnt == 2'b10) who = 1;
      else tick();
    end
    if (who < 0) begin
      chk("grant_wait_expired", gnt, 2'b11);
      who = 0;
    end
  endtask

  // One byte out, one byte back, then a rel pulse; ends on the GAP cycle.
  task automatic xfer(input int p, input logic [7:0] d, input logic [7:0] r);
    int o;
    o = 1 - p;
    tx_valid[p] = 1'b1; tx_data[p] = d;
    tx_valid[o] = 1'b1; tx_data[o] = ~d;
    m_ready = 1'b1;
    settle();
    chk("xfer_m_valid", m_valid, 1'b1);
    chk("xfer_m_data", m_data, d);
    chk("xfer_tx_ready", tx_ready, (p == 1) ? 2'b10 : 2'b01);
    tick();
    tx_valid = '0;
    rx_valid = 1'b1; rx_data = r;
    settle();
    chk("xfer_rx_route", rxv, (p == 1) ? 2'b10 : 2'b01);
    tick();
    rx_valid = 1'b0;
    rel[p] = 1'b1;
    tick();
    rel = '0;
    settle();
    chk("xfer_gap_gnt", gnt, 2'b00);
    chk("xfer_gap_cs_n", m_cs_n, 1'b1);
    $display("txn port=%0d tx=%02h rx=%02h", p, d, r);
  endtask

  initial begin
    int who;
    int cnt;
    logic ok;
    logic exp_w;
    logic [7:0] d1, d2, r1;

    // 1: single requester, full transaction, no DRAIN, one GAP cycle
    do_reset();
    req[0] = 1'b1;
    tick();
    chk("t1_gnt_plus1", gnt, 2'b01);
    chk("t1_cs_low", m_cs_n, 1'b0);
    exp_last = 1'b0;
    req[0] = 1'b0;
    rel[0] = 1'b0;
    tx_valid[0] = 1'b1; tx_data[0] = 8'hA5; m_ready = 1'b1;
    req[0] = 1'b1;
    settle();
    chk("t1_m_data", m_data, 8'hA5);
    chk("t1_tx_ready", tx_ready, 2'b01);
    tick();
    tx_valid = '0;
    rx_valid = 1'b1; rx_data = 8'h3C;
    settle();
    chk("t1_rx0", rxv, 2'b01);
    tick();
    rx_valid = 1'b0; rel[0] = 1'b1; req[0] = 1'b0;
    tick();
    rel = '0;
    settle();
    chk("t1_gap_cs_n", m_cs_n, 1'b1);
    chk("t1_gap_busy", busy, 1'b1);
    tick();
    chk("t1_idle_busy", busy, 1'b0);
    chk("t1_idle_cs_n", m_cs_n, 1'b1);
    $display("txn port=0 tx=a5 rx=3c");

    // 2: contention from reset, both held, order must alternate 0,1,0,1
    do_reset();
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_grant(who);
      exp_w = rr_pick(req, exp_last);
      exp_last = exp_w;
      chk("t2_rr_order", who, exp_w);
      xfer(int'(exp_w), 8'($urandom), 8'($urandom));
    end
    req = 2'b00;
    tick();
    tick();

    // 3: release in the handshake cycle forces DRAIN until rx_valid
    req[1] = 1'b1;
    wait_grant(who);
    exp_w = rr_pick(req, exp_last);
    exp_last = exp_w;
    chk("t3_grant", who, exp_w);
    tx_valid[1] = 1'b1; tx_data[1] = 8'h55; m_ready = 1'b1; rel[1] = 1'b1;
    settle();
    chk("t3_tx1_ready", tx_ready, 2'b10);
    tick();
    rel = '0; req = '0;
    settle();
    chk("t3_drain_cs_n", m_cs_n, 1'b0);
    chk("t3_drain_gnt", gnt, 2'b10);
    chk("t3_drain_m_valid", m_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      chk("t3_drain_hold", {m_cs_n, busy}, 2'b01);
    end
    tx_valid = '0;
    r1 = 8'($urandom);
    rx_valid = 1'b1; rx_data = r1;
    settle();
    chk("t3_rx_route", rxv, 2'b10);
    tick();
    rx_valid = 1'b0;
    settle();
    chk("t3_gap", {gnt, m_cs_n}, 3'b001);
    tick();
    chk("t3_idle", busy, 1'b0);
    $display("txn port=1 tx=55 rx=%02h drain", r1);

    // 4: one byte in flight blocks the next; other port never ready
    d1 = 8'($urandom); d2 = 8'($urandom);
    req[1] = 1'b1;
    wait_grant(who);
    exp_w = rr_pick(req, exp_last);
    exp_last = exp_w;
    chk("t4_grant", who, exp_w);
    tx_valid = 2'b11; tx_data[1] = d1; tx_data[0] = ~d1; m_ready = 1'b0;
    settle();
    chk("t4_m_valid_stall", {m_valid, tx_ready}, 3'b100);
    tick();
    m_ready = 1'b1;
    settle();
    chk("t4_ready1", tx_ready, 2'b10);
    chk("t4_m_data1", m_data, d1);
    tick();
    tx_data[1] = d2;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t4_blocked", {m_valid, tx_ready}, 3'b000);
      tick();
    end
    rx_valid = 1'b1; rx_data = 8'($urandom);
    settle();
    chk("t4_rx1", {rxv, tx_ready}, 4'b1000);
    tick();
    rx_valid = 1'b0;
    settle();
    chk("t4_ready2", tx_ready, 2'b10);
    chk("t4_m_data2", m_data, d2);
    tick();
    tx_valid = '0;
    rx_valid = 1'b1;
    settle();
    chk("t4_rx2", rxv, 2'b10);
    tick();
    rx_valid = 1'b0; rel[1] = 1'b1; req[1] = 1'b0;
    tick();
    rel = '0;
    settle();
    chk("t4_gap_gnt", gnt, 2'b00);
    tick();
    $display("txn port=1 tx=%02h,%02h stalled", d1, d2);

    // 5: hung grant with a byte in flight
    req[0] = 1'b1;
    wait_grant(who);
    exp_w = rr_pick(req, exp_last);
    exp_last = exp_w;
    chk("t5_grant", who, exp_w);
    tx_valid[0] = 1'b1; tx_data[0] = 8'($urandom); m_ready = 1'b1;
    settle();
    chk("t5_tx0_ready", tx_ready, 2'b01);
    tick();
    tx_valid = '0; m_ready = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt = 0;
    while (gnt[0] === 1'b1 && timeout !== 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("t5_wdog_span_ok", (cnt >= 15 && cnt <= 16), 1'b1);
    chk("t5_timeout_pulse", timeout, 1'b1);
    chk("t5_to_gnt_cs", {gnt, m_cs_n}, 3'b001);
    req[0] = 1'b0;
    rx_valid = 1'b1;
    settle();
    chk("t5_late_rx_dropped", rxv, 2'b00);
    tick();
    rx_valid = 1'b0;
    chk("t5_timeout_1cycle", timeout, 1'b0);
    $display("txn port=0 watchdog after %0d cycles", cnt);
`else
    ok = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      cnt++;
      if (gnt !== 2'b01 || timeout !== 1'b0 || m_cs_n !== 1'b0) ok = 1'b0;
    end
    chk("t5_hold_100", ok, 1'b1);
    rel[0] = 1'b1; req[0] = 1'b0;
    tick();
    rel = '0;
    settle();
    chk("t5_drain", {gnt, m_cs_n}, 3'b010);
    rx_valid = 1'b1;
    settle();
    chk("t5_rx0", rxv, 2'b01);
    tick();
    rx_valid = 1'b0;
    chk("t5_gap", {gnt, m_cs_n}, 3'b001);
    $display("txn port=0 held %0d cycles without watchdog", cnt);
`endif
    tick();
    tick();

    // 6: async reset while in DRAIN, then RR order restarts with port 0
    req[1] = 1'b1;
    wait_grant(who);
    chk("t6_grant", who, 1);
    tx_valid[1] = 1'b1; tx_data[1] = 8'($urandom); m_ready = 1'b1; rel[1] = 1'b1;
    tick();
    rel = '0;
    settle();
    chk("t6_in_drain", {gnt, m_cs_n}, 3'b100);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_gnt", gnt, 2'b00);
    chk("t6_rst_cs_m", {m_cs_n, m_valid, busy}, 3'b100);
    req = 2'b11;
    tx_valid = '0;
    #1 rst_n = 1'b1;
    exp_last = 1'b1;
    tick();
    chk("t6_rr_after_reset", gnt, rr_pick(req, exp_last) ? 2'b10 : 2'b01);
    $display("txn reset in drain, regrant gnt=%b", gnt);
    clear_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
